// File: rtl/time_inc_arbiter.sv
// time_inc_arbiter
//   Merges the increment requesters that share the clock and alarm time
//   counters. It sends at most one increment per cycle into each counter set.
//   Requests that lose arbitration wait in small saturating pending counters,
//   so no increment is lost unless a counter is already full.
//
// Ports
//   ck             clock, rising edge
//   reset          synchronous active-high clear of all state
//   tick_min       minute carry from the seconds chain (clock minutes, top priority)
//   mm_clock_req   minute button, clock minutes
//   mm_alarm_req   minute button, alarm minutes
//   hh_clock_req   hour button, clock hours
//   hh_alarm_req   hour button, alarm hours
//   ovf_clr        clears the sticky overflow flag
//   clock_min_inc  registered one-cycle increment, clock minutes
//   clock_hour_inc registered one-cycle increment, clock hours
//   alarm_min_inc  registered one-cycle increment, alarm minutes
//   alarm_hour_inc registered one-cycle increment, alarm hours
//   busy           registered: some pending counter is nonzero
//   overflow       sticky: a request was dropped at saturation
module time_inc_arbiter #(
  parameter int PEND_W = 2
) (
  input  logic ck,
  input  logic reset,
  input  logic tick_min,
  input  logic mm_clock_req,
  input  logic mm_alarm_req,
  input  logic hh_clock_req,
  input  logic hh_alarm_req,
  input  logic ovf_clr,
  output logic clock_min_inc,
  output logic clock_hour_inc,
  output logic alarm_min_inc,
  output logic alarm_hour_inc,
  output logic busy,
  output logic overflow
);

  localparam int NSRC = 5;
  localparam int TICK = 0;
  localparam int MMC  = 1;
  localparam int HHC  = 2;
  localparam int MMA  = 3;
  localparam int HHA  = 4;

  logic [NSRC-1:0][PEND_W-1:0] pend, pend_d;
  logic [NSRC-1:0][PEND_W:0]   eff, nxt;
  logic [NSRC-1:0]             req, elig, gnt, sat;
  // Round-robin pointers: 0 prefers the minute source, 1 the hour source.
  logic rr_clk, rr_alm;

  assign req = {hh_alarm_req, mm_alarm_req, hh_clock_req, mm_clock_req, tick_min};

  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      eff[i]  = {1'b0, pend[i]} + {{PEND_W{1'b0}}, req[i]};
      elig[i] = (eff[i] != '0);
    end
  end

  // Clock domain: tick always wins; the buttons share what is left.
  // Alarm domain arbitrates independently in the same cycle.
  always_comb begin
    gnt = '0;
    if (elig[TICK])
      gnt[TICK] = 1'b1;
    else if (elig[MMC] && (!elig[HHC] || !rr_clk))
      gnt[MMC] = 1'b1;
    else if (elig[HHC])
      gnt[HHC] = 1'b1;

    if (elig[MMA] && (!elig[HHA] || !rr_alm))
      gnt[MMA] = 1'b1;
    else if (elig[HHA])
      gnt[HHA] = 1'b1;
  end

  // eff can be at most 2^PEND_W. After the grant is subtracted, the top bit
  // is set only when the counter would exceed its maximum.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      nxt[i]    = eff[i] - {{PEND_W{1'b0}}, gnt[i]};
      sat[i]    = nxt[i][PEND_W];
      pend_d[i] = sat[i] ? {PEND_W{1'b1}} : nxt[i][PEND_W-1:0];
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      pend           <= '0;
      rr_clk         <= 1'b0;
      rr_alm         <= 1'b0;
      clock_min_inc  <= 1'b0;
      clock_hour_inc <= 1'b0;
      alarm_min_inc  <= 1'b0;
      alarm_hour_inc <= 1'b0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      pend <= pend_d;
      // A tick grant leaves rr_clk untouched.
      if (gnt[MMC])      rr_clk <= 1'b1;
      else if (gnt[HHC]) rr_clk <= 1'b0;
      if (gnt[MMA])      rr_alm <= 1'b1;
      else if (gnt[HHA]) rr_alm <= 1'b0;
      clock_min_inc  <= gnt[TICK] | gnt[MMC];
      clock_hour_inc <= gnt[HHC];
      alarm_min_inc  <= gnt[MMA];
      alarm_hour_inc <= gnt[HHA];
      busy           <= |pend_d;
      // Set wins over clear.
      overflow       <= (|sat) | (overflow & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_time_inc_arbiter.sv
module tb_time_inc_arbiter;

  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;

  logic ck = 1'b0;
  logic reset, tick_min, mm_clock_req, mm_alarm_req, hh_clock_req, hh_alarm_req, ovf_clr;
  logic clock_min_inc, clock_hour_inc, alarm_min_inc, alarm_hour_inc, busy, overflow;

  always #5 ck = ~ck;

  time_inc_arbiter #(.PEND_W(PEND_W)) dut (
    .ck(ck), .reset(reset), .tick_min(tick_min),
    .mm_clock_req(mm_clock_req), .mm_alarm_req(mm_alarm_req),
    .hh_clock_req(hh_clock_req), .hh_alarm_req(hh_alarm_req),
    .ovf_clr(ovf_clr),
    .clock_min_inc(clock_min_inc), .clock_hour_inc(clock_hour_inc),
    .alarm_min_inc(alarm_min_inc), .alarm_hour_inc(alarm_hour_inc),
    .busy(busy), .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued request counts per source and the preferred
  // side of each round robin, expressed as plain integers.
  int  q_tick, q_mmc, q_hhc, q_mma, q_hha;
  bit  pref_clk_hour, pref_alm_hour;
  bit  m_cmin, m_chour, m_amin, m_ahour, m_busy, m_ovf;

  function automatic int clampq(input int v, inout bit dropped);
    if (v > PMAX) begin dropped = 1'b1; return PMAX; end
    return v;
  endfunction

  task automatic model(input bit t, mc, hc, ma, ha, clr, rst);
    int et, emc, ehc, ema, eha;
    bit dropped;
    if (rst) begin
      q_tick = 0; q_mmc = 0; q_hhc = 0; q_mma = 0; q_hha = 0;
      pref_clk_hour = 0; pref_alm_hour = 0;
      {m_cmin, m_chour, m_amin, m_ahour, m_busy, m_ovf} = '0;
      return;
    end
    et = q_tick + t; emc = q_mmc + mc; ehc = q_hhc + hc;
    ema = q_mma + ma; eha = q_hha + ha;
    {m_cmin, m_chour, m_amin, m_ahour} = '0;
    // clock side
    if (et > 0) begin et--; m_cmin = 1; end
    else if (emc > 0 && (ehc == 0 || !pref_clk_hour)) begin emc--; m_cmin = 1; pref_clk_hour = 1; end
    else if (ehc > 0) begin ehc--; m_chour = 1; pref_clk_hour = 0; end
    // alarm side
    if (ema > 0 && (eha == 0 || !pref_alm_hour)) begin ema--; m_amin = 1; pref_alm_hour = 1; end
    else if (eha > 0) begin eha--; m_ahour = 1; pref_alm_hour = 0; end
    dropped = 0;
    q_tick = clampq(et, dropped);  q_mmc = clampq(emc, dropped);
    q_hhc  = clampq(ehc, dropped); q_mma = clampq(ema, dropped);
    q_hha  = clampq(eha, dropped);
    m_busy = (q_tick + q_mmc + q_hhc + q_mma + q_hha) != 0;
    m_ovf  = dropped ? 1'b1 : (clr ? 1'b0 : m_ovf);
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare all outputs.
  task automatic step(input bit t, mc, hc, ma, ha, clr, rst);
    reset = rst; tick_min = t; mm_clock_req = mc; hh_clock_req = hc;
    mm_alarm_req = ma; hh_alarm_req = ha; ovf_clr = clr;
    model(t, mc, hc, ma, ha, clr, rst);
    @(posedge ck); #1;
    chk("clock_min_inc",  clock_min_inc,  m_cmin);
    chk("clock_hour_inc", clock_hour_inc, m_chour);
    chk("alarm_min_inc",  alarm_min_inc,  m_amin);
    chk("alarm_hour_inc", alarm_hour_inc, m_ahour);
    chk("busy",           busy,           m_busy);
    chk("overflow",       overflow,       m_ovf);
    chk("clk_excl", clock_min_inc & clock_hour_inc, 0);
    chk("alm_excl", alarm_min_inc & alarm_hour_inc, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  int pulses;

  initial begin
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("reset_outs", {clock_min_inc, clock_hour_inc, alarm_min_inc, alarm_hour_inc, busy, overflow}, 0);

    // single pulse, 1-cycle latency, no busy
    idle(3);
    step(0, 1, 0, 0, 0, 0, 0);
    chk("single_min", clock_min_inc, 1);
    chk("single_busy", busy, 0);
    idle(2);

    // tick + both clock buttons: tick, then mm, then hh
    // (previous single mm grant left preference on hour; re-sync first)
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("t3_tick", {clock_min_inc, clock_hour_inc, busy}, 3'b101);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_mm", {clock_min_inc, clock_hour_inc, busy}, 3'b101);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t3_hh", {clock_min_inc, clock_hour_inc, busy}, 3'b010);
    idle(2);

    // all four buttons at once: both domains in parallel
    step(0, 1, 1, 1, 1, 0, 0);
    chk("par1", {clock_min_inc, clock_hour_inc, alarm_min_inc, alarm_hour_inc}, 4'b1010);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("par2", {clock_min_inc, clock_hour_inc, alarm_min_inc, alarm_hour_inc}, 4'b0101);
    idle(2);

    // tick held 10 cycles, 5 mm pulses: saturate at 3, overflow
    for (int i = 0; i < 10; i++) begin
      step(1, i[0], 0, 0, 0, 0, 0);
      chk("tickwin_no_hour", clock_hour_inc, 0);
    end
    chk("tickwin_ovf", overflow, 1);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      pulses += clock_min_inc;
    end
    chk("drain_count", pulses, 3);
    chk("ovf_sticky", overflow, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ovf_clr", overflow, 0);

    // queue alarm requests, reset mid-drain, then pointer back to mm
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("rst_mid", {alarm_min_inc, alarm_hour_inc, busy}, 0);
    idle(3);
    chk("rst_quiet", {alarm_min_inc, alarm_hour_inc, busy}, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    chk("rst_ptr_mm", {alarm_min_inc, alarm_hour_inc}, 2'b10);
    idle(2);

    // random traffic, biased so contention and saturation both occur
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_inc_arbiter.md
Name: time_inc_arbiter

Overview:
- Shares the clock and alarm time counters between increment requesters: minute timekeeping carry, minute-button controller, hour-button controller.
- Guarantees at most one increment pulse per cycle into each counter set, clock and alarm. Simultaneous min/hour increments would collide with the internal minute→hour carry.
- Queues contended requests in small saturating pending counters so that no increment is lost.
- Sits between the button/auto-increment controllers and the clock/alarm counter chains.

Parameters:
PEND_W, 2, width of each pending counter; maximum queued requests per source = 2^PEND_W-1 (default 3)

Ports:
ck  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
tick_min  input  1  minute carry from seconds counter; requests clock minute increment
mm_clock_req  input  1  minute-button request, clock minutes
mm_alarm_req  input  1  minute-button request, alarm minutes
hh_clock_req  input  1  hour-button request, clock hours
hh_alarm_req  input  1  hour-button request, alarm hours
ovf_clr  input  1  clears sticky overflow flag
clock_min_inc  output  1  one-cycle increment to clock minute counter
clock_hour_inc  output  1  one-cycle increment to clock hour counter
alarm_min_inc  output  1  one-cycle increment to alarm minute counter
alarm_hour_inc  output  1  one-cycle increment to alarm hour counter
busy  output  1  any pending counter nonzero
overflow  output  1  sticky: a request was dropped at saturation

Behaviour:
- Each request input is sampled every cycle. Every cycle it is high counts as one request; a level held N cycles equals N requests.
- Five sources, each with a PEND_W-bit pending counter: tick, mm_clock, hh_clock, mm_alarm, hh_alarm.
- Per source per cycle: eff = pend + req.
  - A source is eligible when eff > 0.
  - pend_next = eff - grant.
  - If pend_next exceeds 2^PEND_W-1, hold pend at 2^PEND_W-1 and set overflow.
- Clock domain, one grant per cycle:
  - tick has absolute priority.
  - Otherwise mm_clock and hh_clock arbitrate round-robin with a 1-bit pointer rr_clk.
  - The pointer names the preferred source; reset value = mm.
  - After a mm_clock grant the pointer becomes hh; after a hh_clock grant it becomes mm.
  - A tick grant leaves the pointer unchanged.
  - If only one source is eligible, it is granted regardless of the pointer.
- Alarm domain: mm_alarm and hh_alarm arbitrate round-robin with independent pointer rr_alm (reset = mm), under the same rules. There is no tick source.
- Clock and alarm domains operate fully in parallel: one clock grant and one alarm grant may occur in the same cycle.
- Grant to output mapping:
  - tick or mm_clock → clock_min_inc
  - hh_clock → clock_hour_inc
  - mm_alarm → alarm_min_inc
  - hh_alarm → alarm_hour_inc
- Outputs are registered. A request in cycle t with no contention gives its pulse in cycle t+1, so latency is 1 cycle.
- clock_min_inc and clock_hour_inc are never high together. The same holds for alarm_min_inc and alarm_hour_inc.
- Queued requests drain one per cycle per domain in arbitration order. There are no idle gaps while any eligible source exists.
- busy: registered OR of all pend_next != 0.
- overflow:
  - Set on any saturation event.
  - Cleared by ovf_clr.
  - Set has priority over clear in the same cycle.
- Reset, including mid-operation: all outputs 0, all pending counters 0, both pointers = mm, overflow 0. Requests present in the reset cycle are discarded.

Test Plan:
- Single mm_clock_req pulse at cycle 5 → clock_min_inc high only in cycle 6; busy stays 0; no other output toggles.
- tick_min, mm_clock_req, hh_clock_req all pulse in cycle 10 → clock_min_inc cycle 11 (tick), clock_min_inc cycle 12 (mm), clock_hour_inc cycle 13 (hh); busy high cycles 11–12, low cycle 13; rr_clk = mm afterwards.
- Same-cycle pulses on all four button requests → clock and alarm outputs fire in parallel: cycle+1 clock_min_inc and alarm_min_inc, cycle+2 clock_hour_inc and alarm_hour_inc.
- tick_min held high cycles 20–29 while mm_clock_req pulses 5 times inside that window → no mm grants during window, pend saturates at 3, overflow=1; after tick drops, exactly 3 clock_min_inc pulses; overflow stays 1 until ovf_clr, then 0.
- Queue 3 hh_alarm and 2 mm_alarm requests, assert reset for one cycle mid-drain → next cycle all outputs 0, busy 0, no further pulses; a following single mm_alarm_req is granted first (pointer = mm).
